// File: rtl/hazard_unit.sv
// Hazard detection and stall/flush control for a dual-slot (main + compressed) VLIW pipeline.
// Detects load-use and ID-resolved-branch operand hazards and sequences stalls and IF/ID flushes.
module hazard_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rsc,
  input  logic        id_use_rs2,
  input  logic        id_use_rsc,
  input  logic        id_ctrl,
  input  logic        br_taken,
  input  logic        ex_regwr,
  input  logic        ex_memrd,
  input  logic [4:0]  ex_regdest,
  input  logic        ex_regwrc,
  input  logic [4:0]  ex_regdestc,
  input  logic        mem_memrd,
  input  logic [4:0]  mem_regdest,
  input  logic        stall_clr,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_bubble,
  output logic        ifid_flush,
  output logic [1:0]  state,
  output logic [15:0] stall_count
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_HOLD  = 2'b01,
    ST_FLUSH = 2'b10,
    ST_BAD   = 2'b11
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] count_q, count_d;

  // r0 is hardwired zero, so it can never carry a dependency.
  function automatic logic match(input logic [4:0] r, input logic [4:0] d);
    return (r != 5'd0) && (r == d);
  endfunction

  function automatic logic src_hit(input logic [4:0] d);
    return match(id_rs1, d)
         | (id_use_rs2 & match(id_rs2, d))
         | (id_use_rsc & match(id_rsc, d));
  endfunction

  logic hit_ex, hit_exc, hit_mem;
  logic lu, cx, cm, h1, h2;

  assign hit_ex  = src_hit(ex_regdest);
  assign hit_exc = src_hit(ex_regdestc);
  assign hit_mem = src_hit(mem_regdest);

  assign lu = ex_memrd & hit_ex;
  assign cx = id_ctrl & ((ex_regwr & ~ex_memrd & hit_ex) | (ex_regwrc & hit_exc));
  assign cm = id_ctrl & mem_memrd & hit_mem;

  // A load feeding an ID-resolved branch needs two bubbles; everything else needs one.
  assign h2 = id_valid & lu & id_ctrl;
  assign h1 = id_valid & (lu | cx | cm) & ~h2;

  // NOTE: every output of this block gets a default first so no path leaves a latch.
  always_comb begin
    state_d     = ST_RUN;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;

    unique case (state_q)
      ST_HOLD: begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_bubble = 1'b1;
      end
      ST_FLUSH: begin
        ifid_flush  = 1'b1;
      end
      default: begin
        // ST_RUN, and the unreachable ST_BAD which recovers as RUN.
        if (h2 || h1) begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_bubble = 1'b1;
          state_d     = h2 ? ST_HOLD : ST_RUN;
        end else if (id_valid && id_ctrl && br_taken) begin
          ifid_flush  = 1'b1;
          state_d     = ST_FLUSH;
        end
      end
    endcase

    // Hold the pipeline frozen with a bubble while reset is asserted.
    if (!rst_n) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_bubble = 1'b1;
      ifid_flush  = 1'b0;
    end
  end

  always_comb begin
    count_d = count_q;
    if (stall_clr)
      count_d = 16'd0;
    else if (idex_bubble && (count_q != 16'hFFFF))
      count_d = count_q + 16'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      count_q <= 16'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  assign state       = state_q;
  assign stall_count = count_q;

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 id_valid  input  1  ID stage holds a valid VLIW bundle.
REQ-004 id_rs1, id_rs2  input  5 each  main-slot source registers in ID.
REQ-005 id_rsc  input  5  compressed-slot source register in ID.
REQ-006 id_use_rs2, id_use_rsc  input  1 each  qualify id_rs2 / id_rsc as real sources.
REQ-007 id_ctrl  input  1  ID bundle holds a branch/jump resolved in ID, so it needs operands in ID.
REQ-008 br_taken  input  1  ID-resolved branch/jump is taken; meaningful only when id_ctrl=1.
REQ-009 ex_regwr, ex_memrd  input  1 each  EX main slot writes a register / is a load.
REQ-010 ex_regdest  input  5  EX main-slot destination.
REQ-011 ex_regwrc  input  1  EX compressed slot writes a register.
REQ-012 ex_regdestc  input  5  EX compressed-slot destination.
REQ-013 mem_memrd  input  1  MEM stage holds a load.
REQ-014 mem_regdest  input  5  MEM load destination.
REQ-015 stall_clr  input  1  synchronous clear of stall_count.
REQ-016 pc_en  output  1  PC register update enable.
REQ-017 ifid_en  output  1  IF/ID register update enable.
REQ-018 idex_bubble  output  1  insert NOP bundle into ID/EX.
REQ-019 ifid_flush  output  1  squash the IF/ID contents.
REQ-020 state  output  2  FSM state: RUN=00, HOLD=01, FLUSH=10.
REQ-021 stall_count  output  16  saturating count of bubble cycles.

Function
REQ-022 match(r,d) SHALL be true only when r!=0 and r==d; each source counts only when qualified: rs1 always, rs2 when id_use_rs2=1, rsc when id_use_rsc=1.
REQ-023 LU (load-use) SHALL be true when ex_memrd=1 and any qualified source matches ex_regdest.
REQ-024 CX SHALL be true when id_ctrl=1 and any qualified source matches either ex_regdest with ex_regwr=1 and ex_memrd=0, or ex_regdestc with ex_regwrc=1.
REQ-025 CM SHALL be true when id_ctrl=1, mem_memrd=1, and any qualified source matches mem_regdest.
REQ-026 H2 SHALL be LU and id_ctrl; H1 SHALL be (LU or CX or CM) and not H2; both SHALL be forced to 0 when id_valid=0.
REQ-027 RUN with H2: stall (pc_en=0, ifid_en=0, idex_bubble=1, ifid_flush=0); next state HOLD.
REQ-028 RUN with H1: the same stall; next state RUN, and the hazard is re-evaluated next cycle.
REQ-029 RUN with no hazard, id_valid=1, id_ctrl=1, br_taken=1: pc_en=1, ifid_en=1, idex_bubble=0, ifid_flush=1; next state FLUSH.
REQ-030 RUN otherwise: pc_en=1, ifid_en=1, idex_bubble=0, ifid_flush=0; next state RUN.
REQ-031 A hazard SHALL take priority over br_taken in the same cycle; br_taken is ignored while stalling.
REQ-032 HOLD: unconditional stall outputs as in REQ-027, with all hazard inputs and br_taken ignored; next state RUN.
REQ-033 FLUSH: pc_en=1, ifid_en=1, idex_bubble=0, ifid_flush=1, with hazards, id_valid and br_taken ignored; next state RUN.
REQ-034 The outputs SHALL be combinational from state and the current inputs (Mealy in RUN), so a stall asserts in the detection cycle with zero latency.
REQ-035 stall_count SHALL increment by 1 on each edge where idex_bubble=1, saturate at 0xFFFF, and clear to 0 when stall_clr=1; clear wins over increment.
REQ-036 Encoding 11 SHALL be unreachable; if it is entered, behave as RUN and go to RUN next cycle.

Reset
REQ-037 While rst_n=0: state=00 and stall_count=0 immediately, regardless of clk; outputs pc_en=0, ifid_en=0, idex_bubble=1, ifid_flush=0.
REQ-038 Reset asserted in HOLD or FLUSH SHALL abort the sequence; the first edge after deassertion starts in RUN.

Verification
REQ-039 Load-use: ex_memrd=1, ex_regdest=5, id_rs1=5, id_ctrl=0 -> one cycle with pc_en=0, idex_bubble=1, state stays 00, stall_count 0->1; next cycle with ex_memrd=0 -> pc_en=1.
REQ-040 Branch on load: id_ctrl=1, id_rsc=7, id_use_rsc=1, ex_memrd=1, ex_regdest=7 -> two stall cycles (state 00->01->00), stall_count +2.
REQ-041 Zero register: ex_memrd=1, ex_regdest=0, id_rs1=0 -> no stall; id_rs2=3 with id_use_rs2=0 and ex_regdest=3 -> no stall.
REQ-042 Taken branch with no hazard: br_taken=1 -> ifid_flush=1 for 2 cycles (states 00, 10), pc_en=1 throughout.
REQ-043 Taken branch with CX hazard (ex_regwrc=1, ex_regdestc=9, id_rs1=9) -> stall first, ifid_flush=0; flush follows once the hazard clears.
REQ-044 Saturation/clear: preload stall_count to 0xFFFF via long stall -> holds 0xFFFF; stall_clr=1 during a stall -> 0; rst_n low mid-HOLD -> state=00 asynchronously.
